// File: rtl/flare32_mem_arbiter_pkg.sv
// Shared types for the Flare32 memory arbiter: FSM states, grant owner and
// the read data returned on a timed-out access.
package pkg_mem_arb;

   typedef enum bit [7:0] {
      StIdle = 8'd0,
      StBusy = 8'd1,
      StResp = 8'd2
   } State;

   typedef enum bit {
      GrantFetch = 1'b0,
      GrantData  = 1'b1
   } Grant;

   localparam int unsigned TIMEOUT_RDATA = 32'd0;

endpackage

// File: rtl/flare32_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of one single-ported memory
// bus, alternating on contention and aborting accesses that stall too long.
module flare32_mem_arbiter
   import pkg_mem_arb::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  __clk,
   input  logic                  __rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ack,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dt_req,
   input  logic                  dt_we,
   input  logic [ADDR_WIDTH-1:0] dt_addr,
   input  logic [DATA_WIDTH-1:0] dt_wdata,
   output logic                  dt_ack,
   output logic [DATA_WIDTH-1:0] dt_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  bus_err
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0]         WAIT_LIMIT = CW'(MAX_WAIT);
   localparam logic [CW-1:0]         WAIT_ONE   = CW'(1);
   localparam logic [CW-1:0]         WAIT_ZERO  = {CW{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] TO_RDATA   = DATA_WIDTH'(TIMEOUT_RDATA);

   State                  state_r,      state_s;
   Grant                  last_grant_r, last_grant_s;
   Grant                  cur_grant_r,  cur_grant_s;
   logic [CW-1:0]         wait_cnt_r,   wait_cnt_s;
   logic                  mem_req_r,    mem_req_s;
   logic                  mem_we_r,     mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_addr_r,   mem_addr_s;
   logic [DATA_WIDTH-1:0] mem_wdata_r,  mem_wdata_s;
   logic                  if_ack_r,     if_ack_s;
   logic [DATA_WIDTH-1:0] if_rdata_r,   if_rdata_s;
   logic                  dt_ack_r,     dt_ack_s;
   logic [DATA_WIDTH-1:0] dt_rdata_r,   dt_rdata_s;
   logic                  bus_err_r,    bus_err_s;

   // Next-state and next-output logic; acks and bus_err default low so they pulse.
   always_comb begin
      state_s      = state_r;
      last_grant_s = last_grant_r;
      cur_grant_s  = cur_grant_r;
      wait_cnt_s   = wait_cnt_r;
      mem_req_s    = mem_req_r;
      mem_we_s     = mem_we_r;
      mem_addr_s   = mem_addr_r;
      mem_wdata_s  = mem_wdata_r;
      if_rdata_s   = if_rdata_r;
      dt_rdata_s   = dt_rdata_r;
      if_ack_s     = 1'b0;
      dt_ack_s     = 1'b0;
      bus_err_s    = 1'b0;

      case (state_r)
         StIdle: begin
            if (if_req || dt_req) begin
               // Fetch wins unless data also asks and fetch was served last.
               if (if_req && (!dt_req || (last_grant_r == GrantData))) begin
                  cur_grant_s  = GrantFetch;
                  last_grant_s = GrantFetch;
                  mem_we_s     = 1'b0;
                  mem_addr_s   = if_addr;
                  mem_wdata_s  = DATA_ZERO;
               end else begin
                  cur_grant_s  = GrantData;
                  last_grant_s = GrantData;
                  mem_we_s     = dt_we;
                  mem_addr_s   = dt_addr;
                  mem_wdata_s  = dt_wdata;
               end
               mem_req_s  = 1'b1;
               wait_cnt_s = WAIT_ZERO;
               state_s    = StBusy;
            end else begin
               state_s = StIdle;
            end
         end
         StBusy: begin
            if (mem_ack) begin
               mem_req_s = 1'b0;
               state_s   = StResp;
               if (cur_grant_r == GrantFetch) begin
                  if_ack_s   = 1'b1;
                  if_rdata_s = mem_rdata;
               end else begin
                  dt_ack_s   = 1'b1;
                  dt_rdata_s = mem_we_r ? DATA_ZERO : mem_rdata;
               end
            end else if (wait_cnt_r == WAIT_LIMIT) begin
               mem_req_s = 1'b0;
               bus_err_s = 1'b1;
               state_s   = StResp;
               if (cur_grant_r == GrantFetch) begin
                  if_ack_s   = 1'b1;
                  if_rdata_s = TO_RDATA;
               end else begin
                  dt_ack_s   = 1'b1;
                  dt_rdata_s = TO_RDATA;
               end
            end else begin
               wait_cnt_s = wait_cnt_r + WAIT_ONE;
            end
         end
         StResp: begin
            state_s = StIdle;
         end
         default: begin
            state_s   = StIdle;
            mem_req_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge __clk) begin
      if (!__rst_n) begin
         state_r      <= StIdle;
         last_grant_r <= GrantData;
         cur_grant_r  <= GrantFetch;
         wait_cnt_r   <= WAIT_ZERO;
         mem_req_r    <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= ADDR_ZERO;
         mem_wdata_r  <= DATA_ZERO;
         if_ack_r     <= 1'b0;
         if_rdata_r   <= DATA_ZERO;
         dt_ack_r     <= 1'b0;
         dt_rdata_r   <= DATA_ZERO;
         bus_err_r    <= 1'b0;
      end else begin
         state_r      <= state_s;
         last_grant_r <= last_grant_s;
         cur_grant_r  <= cur_grant_s;
         wait_cnt_r   <= wait_cnt_s;
         mem_req_r    <= mem_req_s;
         mem_we_r     <= mem_we_s;
         mem_addr_r   <= mem_addr_s;
         mem_wdata_r  <= mem_wdata_s;
         if_ack_r     <= if_ack_s;
         if_rdata_r   <= if_rdata_s;
         dt_ack_r     <= dt_ack_s;
         dt_rdata_r   <= dt_rdata_s;
         bus_err_r    <= bus_err_s;
      end
   end

   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign if_ack    = if_ack_r;
   assign if_rdata  = if_rdata_r;
   assign dt_ack    = dt_ack_r;
   assign dt_rdata  = dt_rdata_r;
   assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_flare32_mem_arbiter.sv
// Directed bench for flare32_mem_arbiter: transaction-level reference model
// checked every cycle, plus literal latency/data/ordering expectations.
module tb_flare32_mem_arbiter;

   localparam int MW = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, dt_req = 1'b0, dt_we = 1'b0;
   logic [31:0] if_addr = 32'h0, dt_addr = 32'h0, dt_wdata = 32'h0;
   logic        if_ack, dt_ack, mem_req, mem_we, bus_err;
   logic [31:0] if_rdata, dt_rdata, mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   flare32_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
      .__clk(clk), .__rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
      .dt_ack(dt_ack), .dt_rdata(dt_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0, edge_no = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_no);
      end
   endtask

   // Memory: acks after mem_wait extra cycles (-1 = never); optional stray acks while idle.
   int          mem_wait = 0, mem_cnt = 0;
   logic [31:0] mem_rd_val = 32'h0;
   bit          stray = 1'b0;
   always @(negedge clk) begin
      if (mem_req && !mem_ack) begin
         if (mem_wait >= 0 && mem_cnt == mem_wait) begin
            mem_ack = 1'b1; mem_rdata = mem_rd_val;
         end else begin
            mem_cnt = mem_cnt + 1;
         end
      end else begin
         mem_ack = stray; mem_cnt = 0; mem_rdata = stray ? 32'hBADBAD00 : 32'h0;
      end
   end

   // Reference model: one outstanding transaction, judged by edges elapsed since its grant.
   bit          m_active = 1'b0, m_resp = 1'b0, m_last_data = 1'b1, m_data = 1'b0;
   int          m_start = 0;
   logic        e_if_ack = 1'b0, e_dt_ack = 1'b0, e_mem_req = 1'b0, e_mem_we = 1'b0, e_err = 1'b0;
   logic [31:0] e_if_rdata = 32'h0, e_dt_rdata = 32'h0, e_mem_addr = 32'h0, e_mem_wdata = 32'h0;

   task automatic m_complete(input logic [31:0] val, input logic err);
      m_active = 1'b0; m_resp = 1'b1; e_mem_req = 1'b0; e_err = err;
      if (m_data) begin e_dt_ack = 1'b1; e_dt_rdata = val; end
      else        begin e_if_ack = 1'b1; e_if_rdata = val; end
   endtask

   always @(posedge clk) begin
      edge_no++;
      if (!rst_n) begin
         m_active = 1'b0; m_resp = 1'b0; m_last_data = 1'b1;
         e_if_ack = 1'b0; e_dt_ack = 1'b0; e_mem_req = 1'b0; e_mem_we = 1'b0; e_err = 1'b0;
         e_if_rdata = 32'h0; e_dt_rdata = 32'h0; e_mem_addr = 32'h0; e_mem_wdata = 32'h0;
      end else if (m_resp) begin
         m_resp = 1'b0; e_if_ack = 1'b0; e_dt_ack = 1'b0; e_err = 1'b0;
      end else if (!m_active) begin
         if (if_req || dt_req) begin
            m_data      = dt_req && (!if_req || !m_last_data);
            m_last_data = m_data;
            m_active    = 1'b1;
            m_start     = edge_no;
            e_mem_req   = 1'b1;
            e_mem_we    = m_data ? dt_we : 1'b0;
            e_mem_addr  = m_data ? dt_addr : if_addr;
            e_mem_wdata = m_data ? dt_wdata : 32'h0;
         end
      end else if (mem_ack) begin
         m_complete(e_mem_we ? 32'h0 : mem_rdata, 1'b0);
      end else if (edge_no - m_start == MW + 1) begin
         m_complete(32'h0, 1'b1);
      end
   end

   // Per-cycle comparison against the model, and ack event capture for directed checks.
   bit          ev_if = 1'b0, ev_dt = 1'b0, ev_err = 1'b0;
   int          ev_edge = 0;
   logic [31:0] ev_rdata = 32'h0;
   int          ack_port_q[$], ack_edge_q[$];
   always @(negedge clk) begin
      if (chk_en) begin
         chk("if_ack", {31'h0, if_ack}, {31'h0, e_if_ack});
         chk("if_rdata", if_rdata, e_if_rdata);
         chk("dt_ack", {31'h0, dt_ack}, {31'h0, e_dt_ack});
         chk("dt_rdata", dt_rdata, e_dt_rdata);
         chk("mem_req", {31'h0, mem_req}, {31'h0, e_mem_req});
         chk("mem_we", {31'h0, mem_we}, {31'h0, e_mem_we});
         chk("mem_addr", mem_addr, e_mem_addr);
         chk("mem_wdata", mem_wdata, e_mem_wdata);
         chk("bus_err", {31'h0, bus_err}, {31'h0, e_err});
         if (if_ack || dt_ack) begin
            ev_if = if_ack; ev_dt = dt_ack; ev_edge = edge_no; ev_err = bus_err;
            ev_rdata = dt_ack ? dt_rdata : if_rdata;
            ack_port_q.push_back(dt_ack ? 1 : 0);
            ack_edge_q.push_back(edge_no);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   logic [31:0] g_addr;
   logic        g_we;

   task automatic run_req(input bit is_data, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input int wait_c, input logic [31:0] rd,
                          output int lat, output bit err, output logic [31:0] rdata);
      int s;
      bit got;
      mem_wait = wait_c; mem_rd_val = rd;
      ev_if = 1'b0; ev_dt = 1'b0;
      if (is_data) begin dt_req = 1'b1; dt_we = we; dt_addr = addr; dt_wdata = wd; end
      else         begin if_req = 1'b1; if_addr = addr; end
      s = edge_no + 1;
      got = 1'b0;
      lat = -1; err = 1'b0; rdata = 32'hXXXXXXXX;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (i == 0) begin g_addr = mem_addr; g_we = mem_we; end
         if (is_data ? ev_dt : ev_if) got = 1'b1;
      end
      if (!got) chk("ack_wait_expired", 32'h0, 32'h1);
      else begin lat = ev_edge - s; err = ev_err; rdata = ev_rdata; end
      if (is_data) dt_req = 1'b0; else if_req = 1'b0;
      tick();
   endtask

   int          lat;
   bit          err;
   logic [31:0] rd;

   initial begin
      tick();
      chk_en = 1'b1;
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
      rst_n = 1'b1;
      tick();

      // fetch read, zero-wait memory
      run_req(1'b0, 1'b0, 32'h100, 32'h0, 0, 32'hCAFE0001, lat, err, rd);
      chk("fetch_lat", lat, 32'd1);
      chk("fetch_rdata", rd, 32'hCAFE0001);
      chk("fetch_addr", g_addr, 32'h100);
      chk("fetch_err", {31'h0, err}, 32'h0);

      // data write, three wait cycles; read data forced to zero
      run_req(1'b1, 1'b1, 32'h200, 32'h12345678, 3, 32'hDEADBEEF, lat, err, rd);
      chk("wr_lat", lat, 32'd4);
      chk("wr_rdata", rd, 32'h0);
      chk("wr_we", {31'h0, g_we}, 32'h1);
      chk("wr_addr", g_addr, 32'h200);

      // stray mem_ack while idle must not produce anything
      stray = 1'b1; tick(); tick(); tick(); stray = 1'b0; tick();

      // data read that never completes
      run_req(1'b1, 1'b0, 32'h300, 32'h0, -1, 32'h0, lat, err, rd);
      chk("to_lat", lat, 32'd16);
      chk("to_err", {31'h0, err}, 32'h1);
      chk("to_rdata", rd, 32'h0);

      // mem_ack on the last allowed cycle beats the timeout
      run_req(1'b1, 1'b0, 32'h304, 32'h0, 15, 32'h5A5A0F0F, lat, err, rd);
      chk("edge_lat", lat, 32'd16);
      chk("edge_err", {31'h0, err}, 32'h0);
      chk("edge_rdata", rd, 32'h5A5A0F0F);

      // fetch timeout replaces the held fetch data with zero
      run_req(1'b0, 1'b0, 32'h104, 32'h0, -1, 32'h0, lat, err, rd);
      chk("fto_err", {31'h0, err}, 32'h1);
      chk("fto_rdata", rd, 32'h0);

      // contention from reset: fetch, data, fetch, data, one every 3 cycles
      rst_n = 1'b0; tick();
      mem_wait = 0; mem_rd_val = 32'h11112222;
      if_addr = 32'h400; dt_addr = 32'h500; dt_we = 1'b0; dt_wdata = 32'h0;
      if_req = 1'b1; dt_req = 1'b1; rst_n = 1'b1;
      ack_port_q.delete(); ack_edge_q.delete();
      repeat (12) tick();
      if_req = 1'b0; dt_req = 1'b0;
      tick(); tick();
      chk("cont_count", ack_port_q.size(), 32'd4);
      if (ack_port_q.size() >= 4) begin
         chk("cont_0", ack_port_q[0], 32'd0);
         chk("cont_1", ack_port_q[1], 32'd1);
         chk("cont_2", ack_port_q[2], 32'd0);
         chk("cont_3", ack_port_q[3], 32'd1);
         chk("cont_gap", ack_edge_q[1] - ack_edge_q[0], 32'd3);
      end

      // reset while busy: everything clears, request re-granted afterwards
      mem_wait = -1;
      dt_req = 1'b1; dt_we = 1'b0; dt_addr = 32'h600;
      tick(); tick();
      rst_n = 1'b0; tick();
      chk("mrst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("mrst_mem_addr", mem_addr, 32'h0);
      chk("mrst_dt_rdata", dt_rdata, 32'h0);
      chk("mrst_dt_ack", {31'h0, dt_ack}, 32'h0);
      rst_n = 1'b1;
      run_req(1'b1, 1'b0, 32'h600, 32'h0, 0, 32'h00000077, lat, err, rd);
      chk("regrant_lat", lat, 32'd1);
      chk("regrant_rdata", rd, 32'h00000077);

      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
